fp_align_pipe: RTL
==================

# fp_align_pipe

Pipelined, parametrised exponent-alignment stage for the floating-point adder datapath. It accepts two unpacked operands with a valid/ready handshake and restores the hidden bit (or clears it for denormals). It right-shifts the smaller-exponent mantissa by the exponent difference and appends guard/round/sticky bits. The result goes downstream to the mantissa add/normalise stage with the common exponent, two cycles later, under full backpressure.

## Interface
- `EXP_W`, default 8: exponent width.
- `MANT_W`, default 23: stored fraction width, without the hidden bit.
- `ALIGN_W`, derived as MANT_W+4: output mantissa width, laid out as {hidden, fraction, G, R, S}.
- `clk` in, 1 bit: clock, rising edge.
- `rst` in, 1 bit: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `in_valid` in, 1 bit: input operand pair valid.
- `in_ready` out, 1 bit: stage 1 can accept.
- `exp_a`, `exp_b` in, EXP_W bits: biased exponents.
- `mant_a`, `mant_b` in, MANT_W bits: stored fractions.
- `denorm_a`, `denorm_b` in, 1 bit each: 1 = operand is denormal (authoritative; exponent value is ignored).
- `out_valid` out, 1 bit: aligned result valid.
- `out_ready` in, 1 bit: downstream accepts.
- `aligned_a`, `aligned_b` out, ALIGN_W bits each: aligned mantissas, kept in operand order (no swap).
- `exp_out` out, EXP_W bits: common exponent, the larger effective exponent.
- `b_larger` out, 1 bit: 1 when eff_exp_b > eff_exp_a, which means A was shifted.
- `shift_amt` out, EXP_W bits: unclamped exponent difference.

## Operation
- Effective exponent: `denorm ? 1 : exp`.
- Full mantissa: `{~denorm, mant, 3'b000}`.
- Stage 1 (S1), registered on acceptance:
  - compute both effective exponents and `b_larger`;
  - `shift_amt = |eff_a − eff_b|`;
  - `exp_out = max(eff_a, eff_b)`;
  - register both full mantissas unshifted.
- Stage 2 (S2), registered:
  - the non-larger operand is right-shifted by `shift_amt`; on a tie neither is shifted, `b_larger=0`, and B's path is taken with shift 0;
  - bit 0 of the result becomes OR of the shifted bit 0 and every bit shifted out (sticky);
  - if `shift_amt >= ALIGN_W`, the shifted value is all zero except bit 0, which equals the OR of the whole full mantissa;
  - the other operand passes through unchanged.
- Arithmetic: the exponent difference is computed as unsigned EXP_W bits after the compare, so it never wraps. The shift clamp guarantees no out-of-range shift.
- Handshake:
  - input transfer happens when `in_valid && in_ready`; output transfer when `out_valid && out_ready`;
  - `in_valid` may drop at any time; inputs are sampled only on transfer;
  - outputs hold stable while `out_valid && !out_ready`.
- Pipeline control:
  - each stage has a valid flag;
  - S2 loads when S1 is valid and (S2 is empty or S2 transfers out this cycle);
  - S1 loads on input transfer; `in_ready = !s1_valid || s1_moves_to_s2`;
  - a simultaneous input accept, S1→S2 move and output transfer all occur in the same cycle, with no bubble.
- Reset (async, mid-operation included): both valid flags clear immediately and all data registers clear to 0. In-flight operands are discarded, not replayed.
- Reset values of outputs: `out_valid=0`, `aligned_a=0`, `aligned_b=0`, `exp_out=0`, `b_larger=0`, `shift_amt=0`. `in_ready` is 1 the first cycle after reset deasserts.

## Timing
- Latency: 2 cycles from input transfer edge to `out_valid`, when not stalled.
- Throughput: 1 operand pair per cycle under continuous `out_ready=1`.
- Stall:
  - with `out_ready=0` held, at most 2 pairs are buffered;
  - `in_ready` falls in the cycle after the second accept;
  - it returns high in the same cycle `out_ready` rises (combinational path `out_ready` → `in_ready`, permitted).
- No combinational path from data inputs to outputs.

## Structure
- The shared package `fp_pkg` holds:
  - default `EXP_W`/`MANT_W` constants for binary32;
  - the `ALIGN_W` derivation;
  - GRS bit-index constants (`G_BIT=2`, `R_BIT=1`, `S_BIT=0`).
- Sub-module `fp_shift_sticky`: a combinational, parametrised (ALIGN_W, EXP_W) right shifter with clamp and sticky OR. It is instantiated once in S2 for the selected operand.
- Pipeline valid/ready control stays in the top module.

## Test plan
- Equal exponents: A = {exp=127, mant=0}, B = {exp=127, mant=0x400000} → `aligned_a`=0x4000000, `aligned_b`=0x6000000, `exp_out`=127, `shift_amt`=0, `b_larger`=0, 2 cycles later.
- Shift without sticky: A = {130, 0}, B = {127, 0x400000} → `aligned_b`=0x0C00000, `aligned_a`=0x4000000, `exp_out`=130, `shift_amt`=3.
- Sticky and clamp:
  - A = {132, 0}, B = {127, 0x000001} → `aligned_b`=0x0200001;
  - A = {157, 0}, B = {127, 0x000001} (shift 30) → `aligned_b`=0x0000001.
- Denormal: A = {exp=0, mant=0x400000, denorm=1}, B = {1, 0} → `aligned_a`=0x2000000, `aligned_b`=0x4000000, `exp_out`=1, `shift_amt`=0. Repeat with B = {exp=3} → `b_larger`=1, `aligned_a`=0x0800000.
- Backpressure:
  - stream 4 pairs with `out_ready=0` for 5 cycles → only 2 accepted and `in_ready`=0 afterwards, outputs stable;
  - release → remaining pairs delivered in order, one per cycle, no loss or duplication.
- Reset mid-flight: assert `rst` asynchronously with both stages valid → `out_valid`=0 and all outputs 0 before the next edge. After release, a fresh pair emerges after exactly 2 cycles and no stale data appears.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants for the floating-point adder datapath.
//   - binary32 default field widths
//   - aligned mantissa width derivation {hidden, fraction, G, R, S}
//   - guard/round/sticky bit positions within an aligned mantissa
package fp_pkg;

  localparam int EXP_W_DEF   = 8;
  localparam int MANT_W_DEF  = 23;

  // Hidden bit + fraction + 3 extra bits (G, R, S) below the fraction LSB.
  function automatic int align_w(input int mant_w);
    return mant_w + 4;
  endfunction

  localparam int ALIGN_W_DEF = align_w(MANT_W_DEF);

  localparam int G_BIT = 2;
  localparam int R_BIT = 1;
  localparam int S_BIT = 0;

endpackage

// File: rtl/fp_shift_sticky.sv
// fp_shift_sticky: combinational right shifter with sticky collection.
//   val_i   : full mantissa {hidden, fraction, 3'b000}
//   shamt_i : unclamped shift distance
//   res_o   : val_i >> shamt_i, with bit 0 ORed with every bit shifted out.
//             Distances of ALIGN_W or more leave only bit 0 = |val_i.
module fp_shift_sticky
  import fp_pkg::*;
#(
  parameter int ALIGN_W = ALIGN_W_DEF,
  parameter int EXP_W   = EXP_W_DEF
) (
  input  logic [ALIGN_W-1:0] val_i,
  input  logic [EXP_W-1:0]   shamt_i,
  output logic [ALIGN_W-1:0] res_o
);

  logic [31:0]        sh;
  logic [ALIGN_W-1:0] lost;

  assign sh = 32'(shamt_i);

  always_comb begin
    res_o = '0;
    lost  = '0;
    if (sh >= 32'(ALIGN_W)) begin
      // Everything falls off the end; only the sticky survives.
      res_o[S_BIT] = |val_i;
    end else begin
      lost         = val_i & ~({ALIGN_W{1'b1}} << sh);
      res_o        = val_i >> sh;
      res_o[S_BIT] = res_o[S_BIT] | (|lost);
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage exponent alignment for the FP adder.
//   S1 registers effective exponents, compare result, |diff| and the full
//   mantissas; S2 right-shifts the smaller operand with sticky and presents
//   the result downstream. Full valid/ready backpressure, no bubbles.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   in_valid/in_ready         : operand pair handshake
//   exp_a/b, mant_a/b         : biased exponents, stored fractions
//   denorm_a/b                : operand is denormal (exponent ignored)
//   out_valid/out_ready       : result handshake
//   aligned_a/b               : aligned mantissas, operand order kept
//   exp_out                   : larger effective exponent
//   b_larger                  : B's effective exponent strictly larger
//   shift_amt                 : unclamped exponent difference
module fp_align_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W   = EXP_W_DEF,
  parameter  int MANT_W  = MANT_W_DEF,
  localparam int ALIGN_W = MANT_W + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [MANT_W-1:0]  mant_a,
  input  logic [MANT_W-1:0]  mant_b,
  input  logic               denorm_a,
  input  logic               denorm_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALIGN_W-1:0] aligned_a,
  output logic [ALIGN_W-1:0] aligned_b,
  output logic [EXP_W-1:0]   exp_out,
  output logic               b_larger,
  output logic [EXP_W-1:0]   shift_amt
);

  // Same record for both stages: in S1 ma/mb are unshifted, in S2 aligned.
  typedef struct packed {
    logic [ALIGN_W-1:0] ma;
    logic [ALIGN_W-1:0] mb;
    logic [EXP_W-1:0]   ex;
    logic [EXP_W-1:0]   sh;
    logic               bl;
  } stg_t;

  logic [2:1] vld_pipe_q;
  stg_t       s1_q, s1_d, s2_q, s2_d;
  logic       in_fire, s1_move, s2_fire;

  // ---------------- handshake ----------------
  assign s2_fire  = vld_pipe_q[2] && out_ready;
  assign s1_move  = vld_pipe_q[1] && (!vld_pipe_q[2] || out_ready);
  assign in_ready = !vld_pipe_q[1] || s1_move;
  assign in_fire  = in_valid && in_ready;

  // ---------------- S1: compare exponents ----------------
  logic [EXP_W-1:0] eff_a, eff_b;

  always_comb begin
    eff_a   = denorm_a ? EXP_W'(1) : exp_a;
    eff_b   = denorm_b ? EXP_W'(1) : exp_b;
    s1_d    = '0;
    s1_d.ma = {~denorm_a, mant_a, 3'b000};
    s1_d.mb = {~denorm_b, mant_b, 3'b000};
    s1_d.bl = eff_b > eff_a;
    // Subtract in the known-safe order so the difference never wraps.
    s1_d.sh = s1_d.bl ? (eff_b - eff_a) : (eff_a - eff_b);
    s1_d.ex = s1_d.bl ? eff_b : eff_a;
  end

  // ---------------- S2: align the smaller operand ----------------
  // On a tie bl=0, so B takes the shift path with distance 0.
  logic [ALIGN_W-1:0] sh_in, sh_out;

  assign sh_in = s1_q.bl ? s1_q.ma : s1_q.mb;

  fp_shift_sticky #(.ALIGN_W(ALIGN_W), .EXP_W(EXP_W)) u_shift (
    .val_i  (sh_in),
    .shamt_i(s1_q.sh),
    .res_o  (sh_out)
  );

  always_comb begin
    s2_d    = s1_q;
    s2_d.ma = s1_q.bl ? sh_out : s1_q.ma;
    s2_d.mb = s1_q.bl ? s1_q.mb : sh_out;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      if (in_fire)      vld_pipe_q[1] <= 1'b1;
      else if (s1_move) vld_pipe_q[1] <= 1'b0;

      if (s1_move)      vld_pipe_q[2] <= 1'b1;
      else if (s2_fire) vld_pipe_q[2] <= 1'b0;

      if (in_fire) s1_q <= s1_d;
      if (s1_move) s2_q <= s2_d;
    end
  end

  assign out_valid = vld_pipe_q[2];
  assign aligned_a = s2_q.ma;
  assign aligned_b = s2_q.mb;
  assign exp_out   = s2_q.ex;
  assign shift_amt = s2_q.sh;
  assign b_larger  = s2_q.bl;

endmodule
